// File: rtl/sram_port_arbiter_pkg.sv
// Shared helpers for the SRAM port arbiter.
package sram_port_arbiter_pkg;

    // Width of a port index; a single port still gets one index bit.
    function automatic int port_idx_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker. The search starts one past the last
// winner, so the previous winner has the lowest priority this cycle.
module rr_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = port_idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_eligible,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_grant_idx,
    output logic                 o_any_grant
);

    logic [IDX_W:0] w_cand;

    // Walk ports rr_ptr+1 .. rr_ptr+NUM_PORTS (mod NUM_PORTS); first eligible wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_cand      = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_cand = {1'b0, i_rr_ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_PORTS)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_PORTS);
            end
            if (!o_any_grant && i_eligible[w_cand[IDX_W-1:0]]) begin
                o_any_grant                  = 1'b1;
                o_grant[w_cand[IDX_W-1:0]]   = 1'b1;
                o_grant_idx                  = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one single-port SRAM macro between NUM_PORTS
// requesters. Writes complete at the grant edge; reads return through a
// per-port response register two cycles after the handshake.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int WIDTH     = 128,
    parameter int NUM_ROWS  = 4096,
    localparam int AddressWidth = $clog2(NUM_ROWS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_PORTS-1:0]                   req_valid,
    output logic [NUM_PORTS-1:0]                   req_ready,
    input  logic [NUM_PORTS-1:0]                   req_we,
    input  logic [NUM_PORTS-1:0][AddressWidth-1:0] req_addr,
    input  logic [NUM_PORTS-1:0][WIDTH-1:0]        req_wdata,
    input  logic [NUM_PORTS-1:0][WIDTH-1:0]        req_wmask,
    output logic [NUM_PORTS-1:0]                   rsp_valid,
    input  logic [NUM_PORTS-1:0]                   rsp_ready,
    output logic [NUM_PORTS-1:0][WIDTH-1:0]        rsp_rdata,
    output logic                                   sram_ceb,
    output logic                                   sram_web,
    output logic [AddressWidth-1:0]                sram_a,
    output logic [WIDTH-1:0]                       sram_d,
    output logic [WIDTH-1:0]                       sram_m,
    input  logic [WIDTH-1:0]                       sram_q
);

    localparam int IdxW = port_idx_width(NUM_PORTS);

    typedef struct packed {
        logic                    we;
        logic [AddressWidth-1:0] addr;
        logic [WIDTH-1:0]        wdata;
        logic [WIDTH-1:0]        wmask;
    } req_t;

    req_t [NUM_PORTS-1:0]            w_req;
    req_t                            w_sel;
    logic [NUM_PORTS-1:0]            w_eligible;
    logic [NUM_PORTS-1:0]            w_grant_raw;
    logic [NUM_PORTS-1:0]            w_grant;
    logic [IdxW-1:0]                 w_grant_idx;
    logic                            w_any_raw;
    logic                            w_any_grant;

    logic [IdxW-1:0]                 r_rr_ptr;
    logic [NUM_PORTS-1:0]            r_inflight;
    logic [NUM_PORTS-1:0]            r_rsp_valid;
    logic [NUM_PORTS-1:0][WIDTH-1:0] r_rsp_rdata;

    // Bundle request fields and decide who may compete. A read needs a free
    // response slot: nothing in flight and the held response leaving now.
    always_comb begin
        w_req      = '0;
        w_eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_req[p].we    = req_we[p];
            w_req[p].addr  = req_addr[p];
            w_req[p].wdata = req_wdata[p];
            w_req[p].wmask = req_wmask[p];
            w_eligible[p]  = req_valid[p] &&
                             (req_we[p] || (!r_inflight[p] && (!r_rsp_valid[p] || rsp_ready[p])));
        end
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IdxW)
    ) u_rr_arbiter (
        .i_eligible  (w_eligible),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant_raw),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_raw)
    );

    // No access may reach the macro while reset is held.
    assign w_grant     = w_grant_raw & {NUM_PORTS{rst_n}};
    assign w_any_grant = w_any_raw & rst_n;
    assign req_ready   = w_grant;

    // SRAM pin mux: granted port drives the macro, idle pins parked at 0.
    always_comb begin
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        sram_m   = '0;
        w_sel    = w_req[w_grant_idx];
        if (w_any_grant) begin
            sram_ceb = 1'b0;
            sram_web = ~w_sel.we;
            sram_a   = w_sel.addr;
            sram_d   = w_sel.wdata;
            sram_m   = w_sel.wmask;
        end
    end

    // Round-robin pointer remembers the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= IdxW'(NUM_PORTS - 1);
        end else if (w_any_grant) begin
            r_rr_ptr <= w_grant_idx;
        end
    end

    // Read pipeline: mark in flight at grant, capture Q one edge later.
    // A capture overrides a consume landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_inflight[p] <= w_grant[p] & ~req_we[p];
                if (r_inflight[p]) begin
                    r_rsp_valid[p] <= 1'b1;
                    r_rsp_rdata[p] <= sram_q;
                end else if (r_rsp_valid[p] && rsp_ready[p]) begin
                    r_rsp_valid[p] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter with a behavioural masked single-port SRAM.
module tb_sram_port_arbiter;

    localparam int NP   = 2;
    localparam int W    = 128;
    localparam int ROWS = 64;
    localparam int AW   = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NP-1:0]        req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [NP-1:0][AW-1:0] req_addr;
    logic [NP-1:0][W-1:0] req_wdata, req_wmask, rsp_rdata;
    logic                 sram_ceb, sram_web;
    logic [AW-1:0]        sram_a;
    logic [W-1:0]         sram_d, sram_m, sram_q;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic mem_init = 1'b1;

    logic [W-1:0] sram_mem [ROWS];
    logic [W-1:0] exp_mem  [ROWS];

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t sb [NP][$];
    bit   seen [NP];

    sram_port_arbiter #(
        .NUM_PORTS (NP),
        .WIDTH     (W),
        .NUM_ROWS  (ROWS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_m    (sram_m),
        .sram_q    (sram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] pat(input int i);
        return {4{32'h5A00_0000 | i}};
    endfunction

    // Behavioural SRAM: masked write, registered read data.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < ROWS; i++) sram_mem[i] <= pat(i);
            sram_q <= '0;
        end else if (!sram_ceb) begin
            if (!sram_web) sram_mem[sram_a] <= (sram_mem[sram_a] & ~sram_m) | (sram_d & sram_m);
            else           sram_q <= sram_mem[sram_a];
        end
    end

    // Scoreboard: push expected read data at each read handshake, check
    // arrival cycle and data when the response appears / is consumed.
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < ROWS; i++) exp_mem[i] = pat(i);
        end
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin
                sb[p].delete();
                seen[p] = 1'b0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (rsp_valid[p]) begin
                    if (!seen[p]) begin
                        checks++;
                        assert (sb[p].size() > 0 && sb[p][0].due == cyc) else begin
                            errors++;
                            $error("FAIL rsp_timing port%0d: observed response at cycle %0d, expected cycle %0d",
                                   p, cyc, (sb[p].size() > 0) ? sb[p][0].due : -1);
                        end
                        seen[p] = 1'b1;
                    end
                    if (rsp_ready[p]) begin
                        if (sb[p].size() > 0) begin
                            checks++;
                            assert (rsp_rdata[p] === sb[p][0].data) else begin
                                errors++;
                                $error("FAIL rsp_data port%0d: observed %0h expected %0h",
                                       p, rsp_rdata[p], sb[p][0].data);
                            end
                            void'(sb[p].pop_front());
                        end
                        seen[p] = 1'b0;
                    end
                end else if (sb[p].size() > 0 && cyc > sb[p][0].due) begin
                    checks++;
                    errors++;
                    $error("FAIL rsp_timeout port%0d: observed no response at cycle %0d, expected by cycle %0d",
                           p, cyc, sb[p][0].due);
                    void'(sb[p].pop_front());
                end
                if (req_valid[p] && req_ready[p]) begin
                    if (req_we[p]) begin
                        exp_mem[req_addr[p]] = (exp_mem[req_addr[p]] & ~req_wmask[p]) |
                                               (req_wdata[p] & req_wmask[p]);
                    end else begin
                        sb[p].push_back('{exp_mem[req_addr[p]], cyc + 2});
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ready(input string tag, input logic [NP-1:0] exp);
        #1;
        chk(tag, W'(req_ready), W'(exp));
    endtask

    task automatic drive(input int p, input logic we, input logic [AW-1:0] addr,
                         input logic [W-1:0] wdata, input logic [W-1:0] wmask);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_addr[p]  = addr;
        req_wdata[p] = wdata;
        req_wmask[p] = wmask;
    endtask

    task automatic drop(input int p);
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(input int p, input string tag, input logic [W-1:0] exp);
        for (int n = 0; n < 6; n++) begin
            if (rsp_valid[p]) begin
                chk(tag, rsp_rdata[p], exp);
                return;
            end
            step();
        end
        checks++;
        errors++;
        $error("FAIL %s: observed no rsp_valid on port %0d within 6 cycles, expected 1", tag, p);
    endtask

    initial begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = '1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ceb", W'(sram_ceb), W'(1'b1));
        chk("reset_rsp_valid", W'(rsp_valid), '0);
        chk("reset_rdata0", rsp_rdata[0], '0);
        chk("reset_rdata1", rsp_rdata[1], '0);
        mem_init = 1'b0;
        rst_n    = 1'b1;
        step();

        // Both ports stream reads: grants alternate starting at port 0
        drive(0, 1'b0, 6'd8,  '0, '0);
        drive(1, 1'b0, 6'd16, '0, '0);
        for (int i = 0; i < 4; i++) begin
            expect_ready($sformatf("rr_alt%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
            if (i % 2 == 0) req_addr[0] = req_addr[0] + 6'd1;
            else            req_addr[1] = req_addr[1] + 6'd1;
        end
        drop(0);
        drop(1);
        repeat (4) step();

        // Port0 writes addr 5, port1 reads it back
        drive(0, 1'b1, 6'd5, {16{8'hA5}}, '1);
        expect_ready("wr5_ready", 2'b01);
        chk("wr5_ceb", W'(sram_ceb), W'(1'b0));
        chk("wr5_web", W'(sram_web), W'(1'b0));
        chk("wr5_addr", W'(sram_a), W'(6'd5));
        step();
        drop(0);
        drive(1, 1'b0, 6'd5, '0, '0);
        expect_ready("rd5_ready", 2'b10);
        chk("rd5_web", W'(sram_web), W'(1'b1));
        step();
        drop(1);
        wait_rsp(1, "rd5_data", {16{8'hA5}});
        repeat (2) step();

        // Port0 backpressure: second read blocked until rsp_ready returns
        rsp_ready[0] = 1'b0;
        drive(0, 1'b0, 6'd10, '0, '0);
        expect_ready("bp_first", 2'b01);
        step();
        drop(0);
        step();
        drive(0, 1'b0, 6'd11, '0, '0);
        drive(1, 1'b1, 6'd20, {4{32'hBEEF_0000}}, '1);
        for (int i = 0; i < 3; i++) begin
            expect_ready($sformatf("bp_blocked%0d", i), 2'b10);
            chk($sformatf("bp_hold%0d", i), W'(rsp_valid[0]), W'(1'b1));
            step();
            req_addr[1]  = 6'(21 + i);
            req_wdata[1] = {4{32'hBEEF_0001 + 32'(i)}};
        end
        rsp_ready[0] = 1'b1;
        expect_ready("bp_release", 2'b01);
        step();
        drop(0);
        drop(1);
        wait_rsp(0, "bp_second", pat(11));
        repeat (2) step();

        // Partial write mask
        drive(0, 1'b1, 6'd3, '1, '1);
        expect_ready("mask_wr1", 2'b01);
        step();
        drive(0, 1'b1, 6'd3, '0, {8{16'h00FF}});
        expect_ready("mask_wr2", 2'b01);
        step();
        drive(0, 1'b0, 6'd3, '0, '0);
        step();
        drop(0);
        wait_rsp(0, "mask_data", {8{16'hFF00}});
        repeat (2) step();

        // Reset while a port0 read is in flight
        drive(0, 1'b0, 6'd4, '0, '0);
        expect_ready("pre_reset_rd", 2'b01);
        step();
        drop(0);
        drive(1, 1'b0, 6'd12, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("in_reset_ceb", W'(sram_ceb), W'(1'b1));
        step();
        chk("in_reset_rsp_valid", W'(rsp_valid), '0);
        step();
        drive(0, 1'b0, 6'd4, '0, '0);
        rst_n = 1'b1;
        chk("post_reset_rsp_valid", W'(rsp_valid), '0);
        expect_ready("post_reset_first", 2'b01);
        step();
        expect_ready("post_reset_second", 2'b10);
        step();
        drop(0);
        drop(1);
        repeat (4) step();

        // Write then read the same address on the next cycle
        drive(0, 1'b1, 6'd7, {4{32'h1234_5678}}, '1);
        expect_ready("raw_wr", 2'b01);
        step();
        drop(0);
        drive(1, 1'b0, 6'd7, '0, '0);
        expect_ready("raw_rd", 2'b10);
        step();
        drop(1);
        wait_rsp(1, "raw_data", {4{32'h1234_5678}});

        repeat (4) step();
        chk("sb_drained", W'(sb[0].size() + sb[1].size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed simulation still running at 100000, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares one single_port_tsmc_sram instance among NUM_PORTS requesters using round-robin arbitration with valid/ready handshakes. It drives the SRAM's CEB/WEB/A/D/M pins and routes read data back to the requester that issued the read. Each port has its own response register with valid/ready backpressure. It sits between compute/DMA clients and each shared SRAM macro.

Parameters:
NUM_PORTS, 2, number of requesters (>=2)
WIDTH, 128, data/mask width; matches the SRAM WIDTH
NUM_ROWS, 4096, SRAM depth; AddressWidth = $clog2(NUM_ROWS) (localparam)

Ports:
clk  in  1  clock; also drives the SRAM CLK
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_PORTS  per-port request valid
req_ready  out  NUM_PORTS  per-port request accepted this cycle (one-hot or zero)
req_we  in  NUM_PORTS  1 = write, 0 = read
req_addr  in  NUM_PORTS x AddressWidth  row address
req_wdata  in  NUM_PORTS x WIDTH  write data
req_wmask  in  NUM_PORTS x WIDTH  write bit mask (1 = overwrite)
rsp_valid  out  NUM_PORTS  read data valid
rsp_ready  in  NUM_PORTS  read data consumed
rsp_rdata  out  NUM_PORTS x WIDTH  per-port read data
sram_ceb  out  1  to SRAM CEB (active low)
sram_web  out  1  to SRAM WEB (0 = write)
sram_a  out  AddressWidth  to SRAM A
sram_d  out  WIDTH  to SRAM D
sram_m  out  WIDTH  to SRAM M
sram_q  in  WIDTH  from SRAM Q

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid = 0, inflight = 0, rr_ptr = NUM_PORTS-1 (port 0 has highest priority first), rsp_rdata = 0. sram_ceb = 1 while in reset.
- Eligibility of port p: req_valid[p] && (req_we[p] || (!inflight[p] && (!rsp_valid[p] || rsp_ready[p]))). Writes are never blocked by response state.
- Arbitration is combinational, in the same cycle. Search eligible ports starting at rr_ptr+1 with wrap-around; the first eligible port g is granted. req_ready[g] = 1 and all others are 0. Ineligible ports never see req_ready.
- On a grant: sram_ceb = 0, sram_web = ~req_we[g], sram_a/d/m = port g fields. With no grant: sram_ceb = 1, sram_web = 1, and the other SRAM outputs are don't-care (drive 0).
- rr_ptr <= g on each grant edge and is unchanged otherwise.
- Read pipeline: grant at edge k, so the SRAM captures at edge k and Q is valid during cycle k+1. inflight[g] is set at edge k. At edge k+1, rsp_rdata[g] <= sram_q, rsp_valid[g] <= 1, inflight[g] <= 0. Read latency is 2 cycles from handshake to rsp_valid.
- rsp_valid[p] and rsp_rdata[p] hold until the rsp_valid && rsp_ready handshake, then rsp_valid clears unless a new capture lands at the same edge (capture wins).
- Each port has at most one read in flight. Back-to-back reads from the same port issue every 2 cycles at best. Reads from different ports may issue every cycle.
- A write completes at the grant edge and produces no response. A read to the same address one cycle later returns the new data.
- Simultaneous rsp_ready with a new read grant on the same port is legal: the slot is freed at that edge and refilled one cycle later.
- Reset mid-operation discards in-flight reads and pending responses. The SRAM array contents are not affected.
- Request fields must be stable while req_valid is high and not yet accepted. No combinational path exists from rsp_ready to rsp_valid.

Decomposition:
- Package sram_port_arbiter_pkg holds the PortIdxWidth function/constant ($clog2(NUM_PORTS)) and the request struct typedef (we, addr, wdata, wmask), parameterised through localparams in the module.
- Sub-module rr_arbiter (NUM_PORTS; inputs: eligible vector and rr_ptr; outputs: one-hot grant, grant index, any_grant) is purely combinational. The pointer register stays in the parent.
- The parent holds the SRAM pin mux, the inflight and response registers, and an instantiated single_port_tsmc_sram in the bench only.

Test Plan:
- Port0 writes addr 5, data 0xA5..A5, mask all-ones; then port1 reads addr 5 -> port1 sees rsp_valid 2 cycles after its handshake with rdata 0xA5..A5; port0 sees no rsp_valid.
- Both ports continuously request reads from reset -> grants go 0,1,0,1; rr_ptr alternates; each port's responses stay in order and data matches the addresses.
- Port0 holds rsp_ready = 0 with a pending response and issues a second read -> req_ready[0] stays 0 while port1 reads are granted each cycle; releasing rsp_ready lets port0's read be granted in the same cycle.
- Partial mask: write 0xFFFF..FF to addr 3, then write 0x0 with mask 0x00FF..00FF -> read returns 0xFF00..FF00.
- Port0 read granted, then rst_n pulsed low in the next cycle -> rsp_valid stays 0, sram_ceb = 1 during reset, and port 0 wins first after reset.
- Port0 writes addr 7 and port1 reads addr 7 in the next cycle -> the read returns the newly written data.
